// File: rtl/uart_cmd_receiver.sv
// uart_cmd_receiver: assembles 3-byte UART command frames (cmd, data hi, data lo) and returns a response byte
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   rx_data_i      received byte from UART
//   rx_rdy_i       UART byte valid (level until clr_rx_rdy_o)
//   clr_rx_rdy_o   byte consumed this cycle (combinational)
//   cmd_o          assembled command byte
//   data_o         assembled data word
//   cmd_rdy_o      full frame available (level)
//   clr_cmd_rdy_i  consumer acknowledge for cmd_rdy_o
//   frm_err_o      one-cycle pulse when a partial frame is dropped on inter-byte timeout
//   resp_i         response byte to return
//   send_resp_i    request to transmit resp_i
//   tx_data_o      byte to UART transmitter
//   trmt_o         one-cycle transmit strobe
//   tx_done_i      UART transmit complete
//   resp_sent_o    response transmitted (level)
module uart_cmd_receiver #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_rdy_i,
    output logic        clr_rx_rdy_o,
    output logic [7:0]  cmd_o,
    output logic [15:0] data_o,
    output logic        cmd_rdy_o,
    input  logic        clr_cmd_rdy_i,
    output logic        frm_err_o,
    input  logic [7:0]  resp_i,
    input  logic        send_resp_i,
    output logic [7:0]  tx_data_o,
    output logic        trmt_o,
    input  logic        tx_done_i,
    output logic        resp_sent_o
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_e;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    cmd_hold_q, cmd_hold_d, hi_hold_q, hi_hold_d, cmd_q, cmd_d;
    logic [15:0]   data_q, data_d;
    logic          cmd_rdy_q, cmd_rdy_d, frm_err_q, frm_err_d, complete, timeout;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          trmt_q, trmt_d, tx_busy_q, tx_busy_d, resp_sent_q, resp_sent_d, accept;
    // Every state consumes a waiting byte, so the acknowledge simply mirrors rx_rdy_i.
    assign clr_rx_rdy_o = rx_rdy_i;
    assign timeout      = timer_q == TW'(TIMEOUT - 1);
    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        cmd_hold_d = cmd_hold_q;
        hi_hold_d  = hi_hold_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        frm_err_d  = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: if (rx_rdy_i) begin
                cmd_hold_d = rx_data_i;
                state_d    = WAIT_HI;
            end
            WAIT_HI: if (rx_rdy_i) begin
                hi_hold_d = rx_data_i;
                state_d   = WAIT_LO;
            end else if (timeout) begin
                state_d   = IDLE;
                frm_err_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            WAIT_LO: if (rx_rdy_i) begin
                cmd_d    = cmd_hold_q;
                data_d   = {hi_hold_q, rx_data_i};
                complete = 1'b1;
                state_d  = IDLE;
            end else if (timeout) begin
                state_d   = IDLE;
                frm_err_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A completing frame outranks a simultaneous acknowledge.
        cmd_rdy_d = complete | (cmd_rdy_q & ~clr_cmd_rdy_i);
    end
    always_comb begin
        accept      = send_resp_i & ~tx_busy_q;
        tx_data_d   = accept ? resp_i : tx_data_q;
        trmt_d      = accept;
        tx_busy_d   = accept | (tx_busy_q & ~tx_done_i);
        resp_sent_d = accept ? 1'b0 : (tx_busy_q & tx_done_i) ? 1'b1 : resp_sent_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cmd_hold_q  <= '0;
            hi_hold_q   <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_hold_q  <= cmd_hold_d;
            hi_hold_q   <= hi_hold_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frm_err_q   <= frm_err_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            tx_busy_q   <= tx_busy_d;
            resp_sent_q <= resp_sent_d;
        end
    end
    assign cmd_o       = cmd_q;
    assign data_o      = data_q;
    assign cmd_rdy_o   = cmd_rdy_q;
    assign frm_err_o   = frm_err_q;
    assign tx_data_o   = tx_data_q;
    assign trmt_o      = trmt_q;
    assign resp_sent_o = resp_sent_q;
endmodule

// File: tb/tb_uart_cmd_receiver.sv
// tb_uart_cmd_receiver: randomized and directed checks of uart_cmd_receiver against a frame-level reference model
module tb_uart_cmd_receiver;
    localparam int TIMEOUT = 100;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  rx_data = '0, resp = '0;
    logic        rx_rdy = 1'b0, clr_cmd_rdy = 1'b0, send_resp = 1'b0, tx_done = 1'b0;
    logic        clr_rx_rdy, cmd_rdy, frm_err, trmt, resp_sent;
    logic [7:0]  cmd, tx_data;
    logic [15:0] data;
    int          vecs = 0, errs = 0, clr_cnt = 0, trmt_cnt = 0, frm_cnt = 0;
    bit          rnd_on = 1'b0;
    logic [7:0]  m_cmd, m_tx, b0, b1;
    logic [15:0] m_data;
    bit          m_rdy, m_ferr, m_trmt, m_sent, m_busy, m_done, m_b;
    int          nb, idle;
    always #5 clk = ~clk;
    uart_cmd_receiver #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_rdy_i(rx_rdy), .clr_rx_rdy_o(clr_rx_rdy),
        .cmd_o(cmd), .data_o(data), .cmd_rdy_o(cmd_rdy), .clr_cmd_rdy_i(clr_cmd_rdy), .frm_err_o(frm_err),
        .resp_i(resp), .send_resp_i(send_resp), .tx_data_o(tx_data), .trmt_o(trmt), .tx_done_i(tx_done),
        .resp_sent_o(resp_sent)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: a frame is a byte count plus elapsed idle cycles since the last byte.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cmd = '0; m_data = '0; m_rdy = 0; m_ferr = 0; m_tx = '0; m_trmt = 0; m_sent = 0; m_busy = 0;
            nb = 0; idle = 0; b0 = '0; b1 = '0;
        end else begin
            m_ferr = 0;
            m_done = 0;
            if (rx_rdy) begin
                if (nb == 0) b0 = rx_data;
                else if (nb == 1) b1 = rx_data;
                else begin
                    m_cmd = b0;
                    m_data = {b1, rx_data};
                    m_done = 1;
                end
                nb = (nb + 1) % 3;
                idle = 0;
            end else if (nb > 0) begin
                idle++;
                if (idle == TIMEOUT) begin
                    nb = 0;
                    idle = 0;
                    m_ferr = 1;
                end
            end
            m_rdy = m_done || (m_rdy && !clr_cmd_rdy);
            m_b = m_busy;
            m_trmt = send_resp && !m_b;
            if (m_trmt) begin
                m_tx = resp;
                m_busy = 1;
                m_sent = 0;
            end else if (tx_done && m_b) begin
                m_busy = 0;
                m_sent = 1;
            end
        end
    end
    initial forever begin
        @(posedge clk);
        #1;
        chk("clr_rx_rdy", clr_rx_rdy, rx_rdy);
        chk("cmd", cmd, m_cmd);
        chk("data", data, m_data);
        chk("cmd_rdy", cmd_rdy, m_rdy);
        chk("frm_err", frm_err, m_ferr);
        chk("tx_data", tx_data, m_tx);
        chk("trmt", trmt, m_trmt);
        chk("resp_sent", resp_sent, m_sent);
        clr_cnt += int'(clr_rx_rdy);
        trmt_cnt += int'(trmt);
        frm_cnt += int'(frm_err);
    end
    initial forever begin
        @(negedge clk);
        if (rnd_on) begin
            send_resp = $urandom_range(0, 7) == 0;
            tx_done = $urandom_range(0, 5) == 0;
            clr_cmd_rdy = $urandom_range(0, 9) == 0;
            resp = 8'($urandom);
        end
    end
    // Called at a falling edge: presents one byte for a single rising edge, then leaves gap idle edges.
    task automatic rx_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_rdy = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
        repeat (gap) @(negedge clk);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        rx_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        int c0, t0, f0, k;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset cmd_rdy", cmd_rdy, 0);
        chk("reset cmd", cmd, 0);
        chk("reset data", data, 0);
        chk("reset resp_sent", resp_sent, 0);
        c0 = clr_cnt;
        rx_byte(8'h02, 10);
        rx_byte(8'h12, 10);
        rx_byte(8'h34, 0);
        chk("t1 clr pulses", clr_cnt - c0, 3);
        chk("t1 cmd", cmd, 8'h02);
        chk("t1 data", data, 16'h1234);
        chk("t1 cmd_rdy", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        rx_byte(8'h05, 3);
        rx_byte(8'hAA, 0);
        k = 0;
        for (int i = 1; i <= 200 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (frm_err) k = i;
        end
        @(negedge clk);
        chk("t2 frm_err delay", k, 100);
        chk("t2 cmd_rdy", cmd_rdy, 0);
        rx_byte(8'h06, 2);
        rx_byte(8'h00, 2);
        rx_byte(8'h01, 0);
        chk("t2 cmd", cmd, 8'h06);
        chk("t2 data", data, 16'h0001);
        rx_byte(8'h11, 0);
        rx_byte(8'h22, 0);
        clr_cmd_rdy = 1'b1;
        rx_byte(8'h33, 0);
        clr_cmd_rdy = 1'b0;
        chk("t4 set wins", cmd_rdy, 1);
        chk("t4 data", data, 16'h2233);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("t4 cleared", cmd_rdy, 0);
        t0 = trmt_cnt;
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        chk("t3 trmt", trmt, 1);
        chk("t3 tx_data", tx_data, 8'hA5);
        resp = 8'h11;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        @(negedge clk);
        chk("t3 trmt count", trmt_cnt - t0, 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("t3 resp_sent", resp_sent, 1);
        chk("t3 tx_data held", tx_data, 8'hA5);
        f0 = frm_cnt;
        rx_byte(8'h07, 2);
        do_reset();
        rx_byte(8'h08, 1);
        rx_byte(8'h9A, 1);
        rx_byte(8'hBC, 110);
        chk("t5 cmd", cmd, 8'h08);
        chk("t5 data", data, 16'h9ABC);
        chk("t5 no frm_err", frm_cnt - f0, 0);
        f0 = frm_cnt;
        rx_byte(8'h0C, 0);
        rx_byte(8'hAA, TIMEOUT - 1);
        rx_byte(8'h55, 0);
        chk("t6 cmd", cmd, 8'h0C);
        chk("t6 data", data, 16'hAA55);
        chk("t6 no frm_err", frm_cnt - f0, 0);
        rnd_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 19);
            if (k == 0) do_reset();
            else rx_byte(8'($urandom), k < 3 ? $urandom_range(TIMEOUT - 3, TIMEOUT + 2) : $urandom_range(0, 4));
        end
        rnd_on = 1'b0;
        @(negedge clk);
        send_resp = 1'b0;
        tx_done = 1'b0;
        clr_cmd_rdy = 1'b0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
